spi_peripheral_rw: RTL

- Second-generation SPI peripheral, SPI mode 0 (CPOL=0, CPHA=0): sample on SCK rise, shift out on SCK fall.
- Adds to the first generation: system-clock operation, parametrised field widths, a read command with dummy turnaround, and burst transfers with address auto-increment.
- Sits between the external SPI pins and the register/memory bus.
- SCK, CS and COPI are asynchronous pins and are oversampled in the clk domain.

---
 rtl/spi_pkg.sv | 27 ++
 rtl/spi_pin_sync.sv | 41 ++++
 rtl/spi_peripheral_rw.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the SPI register-bus peripheral.
// Imported by the pin synchroniser and the protocol top.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        WDATA,
        RDATA,
        IGNORE
    } state_t;

    localparam logic [7:0] DEF_WRITE_CMD = 8'hA1;
    localparam logic [7:0] DEF_READ_CMD  = 8'h0B;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int cnt_width(input int c, input int a,
                                     input int d, input int m);
        return $clog2(max2(max2(c, a), max2(d, m)) + 1);
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronises the asynchronous SPI pins into clk and derives SCK edges.
// STAGES must be at least 2.
module spi_pin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sck,
    input  logic cs,
    input  logic copi,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_act,
    output logic copi_s
);

    logic [STAGES-1:0] sck_q;
    logic [STAGES-1:0] cs_q;
    logic [STAGES-1:0] copi_q;
    logic              sck_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_q  <= '0;
            cs_q   <= '1;
            copi_q <= '0;
            sck_d  <= 1'b0;
        end else begin
            sck_q  <= {sck_q[STAGES-2:0], sck};
            cs_q   <= {cs_q[STAGES-2:0], cs};
            copi_q <= {copi_q[STAGES-2:0], copi};
            sck_d  <= sck_q[STAGES-1];
        end
    end

    assign sck_rise = sck_q[STAGES-1] & ~sck_d;
    assign sck_fall = ~sck_q[STAGES-1] & sck_d;
    assign cs_act   = ~cs_q[STAGES-1];
    assign copi_s   = copi_q[STAGES-1];

endmodule

// File: rtl/spi_peripheral_rw.sv
// SPI mode-0 peripheral bridging command/address/data frames onto a
// register bus, with burst writes and prefetching burst reads.
module spi_peripheral_rw
    import spi_pkg::*;
#(
    parameter int               CMD_W       = 8,
    parameter int               ADDR_W      = 24,
    parameter int               DATA_W      = 32,
    parameter logic [CMD_W-1:0] WRITE_CMD   = CMD_W'(DEF_WRITE_CMD),
    parameter logic [CMD_W-1:0] READ_CMD    = CMD_W'(DEF_READ_CMD),
    parameter int               DUMMY_BITS  = 8,
    parameter int               SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              cs,
    input  logic              copi,
    output logic              cipo,
    output logic              cipo_oe,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              rd_miss
);

    localparam int CNT_W = cnt_width(CMD_W, ADDR_W, DATA_W, DUMMY_BITS);
    localparam int SH_W  = max2(max2(CMD_W, ADDR_W), DATA_W);

    logic sck_rise, sck_fall, cs_act, copi_s;

    spi_pin_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .sck     (sck),
        .cs      (cs),
        .copi    (copi),
        .sck_rise(sck_rise),
        .sck_fall(sck_fall),
        .cs_act  (cs_act),
        .copi_s  (copi_s)
    );

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [SH_W-1:0]   shift_in;
    logic [SH_W-1:0]   shifted;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] addr_inc;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] hold_data;
    logic              hold_vld;
    logic              req_pend;
    logic              is_read;
    logic              armed;
    logic [SYNC_STAGES:0] settle;
    logic              last;
    logic              shifting;
    logic              load;
    logic              rd_take;
    logic [CMD_W-1:0]  opcode;
    logic              op_ok;

    assign shifted  = {shift_in[SH_W-2:0], copi_s};
    assign opcode   = shifted[CMD_W-1:0];
    assign op_ok    = (opcode == WRITE_CMD) || (opcode == READ_CMD);
    assign addr_inc = addr_cnt + 1'b1;
    assign shifting = sck_rise && (state != IDLE) && (state != IGNORE);
    assign load     = sck_fall && (state == RDATA) && (bit_cnt == '0);
    assign rd_take  = rd_valid && req_pend;

    assign cipo_oe = cs_act && ((state == DUMMY) || (state == RDATA));
    assign cipo    = cipo_oe & tx_sh[DATA_W-1];

    always_comb begin
        state_nxt = state;
        last      = 1'b0;
        unique case (state)
            CMD:    last = (bit_cnt == CNT_W'(CMD_W - 1));
            ADDR:   last = (bit_cnt == CNT_W'(ADDR_W - 1));
            DUMMY:  last = (bit_cnt == CNT_W'(DUMMY_BITS - 1));
            WDATA:  last = (bit_cnt == CNT_W'(DATA_W - 1));
            RDATA:  last = (bit_cnt == CNT_W'(DATA_W - 1));
            default: last = 1'b0;
        endcase
        if (!cs_act) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:  if (armed) state_nxt = CMD;
                CMD:   if (sck_rise && last)
                           state_nxt = op_ok ? ADDR : IGNORE;
                ADDR:  if (sck_rise && last)
                           state_nxt = is_read ? DUMMY : WDATA;
                DUMMY: if (sck_rise && last) state_nxt = RDATA;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A frame already in progress when reset lifts must not be decoded:
    // arm only after the synchroniser has flushed and CS is seen idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle <= '0;
            armed  <= 1'b0;
        end else begin
            settle <= {settle[SYNC_STAGES-1:0], 1'b1};
            if (settle[SYNC_STAGES] && !cs_act) armed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            shift_in  <= '0;
            addr_cnt  <= '0;
            tx_sh     <= '0;
            hold_data <= '0;
            hold_vld  <= 1'b0;
            req_pend  <= 1'b0;
            is_read   <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_req    <= 1'b0;
            rd_addr   <= '0;
            rd_miss   <= 1'b0;
        end else begin
            wr_en   <= 1'b0;
            rd_req  <= 1'b0;
            rd_miss <= 1'b0;
            if (!cs_act) begin
                bit_cnt  <= '0;
                shift_in <= '0;
                tx_sh    <= '0;
                hold_vld <= 1'b0;
                req_pend <= 1'b0;
                is_read  <= 1'b0;
            end else begin
                if (shifting) begin
                    shift_in <= shifted;
                    bit_cnt  <= last ? '0 : bit_cnt + 1'b1;
                end
                if (sck_rise && last && state == CMD)
                    is_read <= (opcode == READ_CMD);
                if (sck_rise && last && state == ADDR) begin
                    addr_cnt <= shifted[ADDR_W-1:0];
                    if (is_read) begin
                        rd_req   <= 1'b1;
                        rd_addr  <= shifted[ADDR_W-1:0];
                        req_pend <= 1'b1;
                    end
                end
                if (sck_rise && last && state == WDATA) begin
                    wr_en    <= 1'b1;
                    wr_addr  <= addr_cnt;
                    wr_data  <= shifted[DATA_W-1:0];
                    addr_cnt <= addr_inc;
                end
                // Word boundary: hand over prefetched data, issue next fetch.
                if (load) begin
                    if (hold_vld) begin
                        tx_sh <= hold_data;
                    end else if (rd_take) begin
                        tx_sh <= rd_data;
                    end else begin
                        tx_sh   <= '0;
                        rd_miss <= 1'b1;
                    end
                    hold_vld <= 1'b0;
                    addr_cnt <= addr_inc;
                    rd_req   <= 1'b1;
                    rd_addr  <= addr_inc;
                    req_pend <= 1'b1;
                end else begin
                    if (sck_fall && state == RDATA)
                        tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
                    if (rd_take) begin
                        hold_data <= rd_data;
                        hold_vld  <= 1'b1;
                        req_pend  <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
